// File: rtl/mdac_code_loader.sv
// Serial-to-parallel DAC code loader: captures an MSB-first frame framed by sen,
// holds the assembled code until the downstream stage accepts it, and flags framing errors.
module mdac_code_loader #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sen,
  input  logic             sdi,
  input  logic             out_ready,
  input  logic             err_clr,
  output logic [WIDTH-1:0] code_out,
  output logic             out_valid,
  output logic             busy,
  output logic             err_short,
  output logic             err_overrun
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StShift, StHold} state_e;

  state_e             r_state, w_state;
  logic               r_sen_d;
  logic [WIDTH-1:0]   r_shift, w_shift;
  logic [CntW-1:0]    r_cnt, w_cnt;
  logic [WIDTH-1:0]   r_code, w_code;
  logic               r_valid, w_valid;
  logic               r_busy, w_busy;
  logic               r_err_short, w_err_short;
  logic               r_err_ovr, w_err_ovr;
  logic               w_frame_start;
  logic               w_set_short;
  logic               w_set_ovr;
  logic [WIDTH-1:0]   w_shifted;

  assign w_frame_start = sen & ~r_sen_d;
  assign w_shifted     = {r_shift[WIDTH-2:0], sdi};

  always_comb begin
    w_state     = r_state;
    w_shift     = r_shift;
    w_cnt       = r_cnt;
    w_code      = r_code;
    w_valid     = r_valid;
    w_set_short = 1'b0;
    w_set_ovr   = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_frame_start) begin
          w_shift = {{(WIDTH-1){1'b0}}, sdi};
          w_cnt   = CntW'(1);
          w_state = StShift;
        end
      end
      StShift: begin
        if (sen) begin
          w_shift = w_shifted;
          if (r_cnt == LastCnt) begin
            w_code  = w_shifted;
            w_valid = 1'b1;
            w_cnt   = '0;
            w_state = StHold;
          end else begin
            w_cnt = r_cnt + CntW'(1);
          end
        end else begin
          // Early sen drop: partial word is discarded, previous code kept.
          w_set_short = 1'b1;
          w_shift     = '0;
          w_cnt       = '0;
          w_state     = StIdle;
        end
      end
      StHold: begin
        // sdi is ignored here; a rising sen on the accepting edge is not a frame start.
        w_set_ovr = sen;
        if (r_valid && out_ready) begin
          w_valid = 1'b0;
          w_state = StIdle;
        end
      end
      default: w_state = StIdle;
    endcase
    w_busy      = (w_state != StIdle);
    w_err_short = w_set_short | (r_err_short & ~err_clr);
    w_err_ovr   = w_set_ovr | (r_err_ovr & ~err_clr);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= StIdle;
      r_sen_d     <= 1'b0;
      r_shift     <= '0;
      r_cnt       <= '0;
      r_code      <= '0;
      r_valid     <= 1'b0;
      r_busy      <= 1'b0;
      r_err_short <= 1'b0;
      r_err_ovr   <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_sen_d     <= sen;
      r_shift     <= w_shift;
      r_cnt       <= w_cnt;
      r_code      <= w_code;
      r_valid     <= w_valid;
      r_busy      <= w_busy;
      r_err_short <= w_err_short;
      r_err_ovr   <= w_err_ovr;
    end
  end

  assign code_out    = r_code;
  assign out_valid   = r_valid;
  assign busy        = r_busy;
  assign err_short   = r_err_short;
  assign err_overrun = r_err_ovr;

endmodule

// File: tb/tb_mdac_code_loader.sv
// Directed self-checking bench for mdac_code_loader at WIDTH=8.
module tb_mdac_code_loader;

  logic       clk = 1'b0;
  logic       reset;
  logic       sen;
  logic       sdi;
  logic       out_ready;
  logic       err_clr;
  logic [7:0] code_out;
  logic       out_valid;
  logic       busy;
  logic       err_short;
  logic       err_overrun;

  int n_checks = 0;
  int n_fail   = 0;

  mdac_code_loader #(.WIDTH(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .sen        (sen),
    .sdi        (sdi),
    .out_ready  (out_ready),
    .err_clr    (err_clr),
    .code_out   (code_out),
    .out_valid  (out_valid),
    .busy       (busy),
    .err_short  (err_short),
    .err_overrun(err_overrun)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; sen = 1'b1; sdi = 1'b1; out_ready = 1'b0; err_clr = 1'b0;
    tick();
    n_checks++;
    if (code_out !== 8'h00) begin n_fail++; $display("FAIL rst_code got=%h exp=00", code_out); end
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got=%b exp=0", out_valid); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got=%b exp=0", busy); end
    n_checks++;
    if ({err_short, err_overrun} !== 2'b00) begin
      n_fail++; $display("FAIL rst_errs got=%b%b exp=00", err_short, err_overrun);
    end
    sen = 1'b0; sdi = 1'b0;
    #2 reset = 1'b1;
    tick();
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_idle_busy got=%b exp=0", busy); end
  endtask

  task automatic test_basic();
    logic [7:0] v = 8'hA5;
    out_ready = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      sen = 1'b1; sdi = v[i];
      tick();
      n_checks++;
      if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy bit=%0d got=%b exp=1", i, busy); end
      n_checks++;
      if (out_valid !== (i == 0)) begin
        n_fail++; $display("FAIL basic_latency bit=%0d got=%b exp=%b", i, out_valid, (i == 0));
      end
    end
    n_checks++;
    if (code_out !== 8'hA5) begin n_fail++; $display("FAIL basic_code got=%h exp=a5", code_out); end
    sen = 1'b0; sdi = 1'b0;
    tick();
    n_checks++;
    if ({out_valid, busy} !== 2'b00) begin
      n_fail++; $display("FAIL basic_accept valid,busy got=%b%b exp=00", out_valid, busy);
    end
    n_checks++;
    if (code_out !== 8'hA5) begin n_fail++; $display("FAIL basic_keep got=%h exp=a5", code_out); end
  endtask

  task automatic test_hold();
    logic [7:0] v = 8'h3C;
    out_ready = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      sen = 1'b1; sdi = v[i];
      tick();
    end
    n_checks++;
    if ({out_valid, code_out} !== {1'b1, 8'h3C}) begin
      n_fail++; $display("FAIL hold_first got=%b/%h exp=1/3c", out_valid, code_out);
    end
    for (int c = 0; c < 5; c++) begin
      sen = (c == 2); sdi = 1'b1;
      tick();
      n_checks++;
      if ({out_valid, code_out} !== {1'b1, 8'h3C}) begin
        n_fail++; $display("FAIL hold_stable c=%0d got=%b/%h exp=1/3c", c, out_valid, code_out);
      end
    end
    n_checks++;
    if (err_overrun !== 1'b1) begin n_fail++; $display("FAIL hold_overrun got=%b exp=1", err_overrun); end
    sen = 1'b0; out_ready = 1'b1;
    tick();
    n_checks++;
    if ({out_valid, busy, code_out} !== {2'b00, 8'h3C}) begin
      n_fail++; $display("FAIL hold_accept got=%b%b/%h exp=00/3c", out_valid, busy, code_out);
    end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    n_checks++;
    if (err_overrun !== 1'b0) begin n_fail++; $display("FAIL hold_clr got=%b exp=0", err_overrun); end
  endtask

  task automatic test_short();
    logic [4:0] p = 5'b10110;
    logic [7:0] v = 8'h81;
    out_ready = 1'b1;
    for (int i = 4; i >= 0; i--) begin
      sen = 1'b1; sdi = p[i];
      tick();
    end
    sen = 1'b0; sdi = 1'b0;
    tick();
    n_checks++;
    if (err_short !== 1'b1) begin n_fail++; $display("FAIL short_flag got=%b exp=1", err_short); end
    n_checks++;
    if ({out_valid, busy, code_out} !== {2'b00, 8'h3C}) begin
      n_fail++; $display("FAIL short_keep got=%b%b/%h exp=00/3c", out_valid, busy, code_out);
    end
    for (int i = 7; i >= 0; i--) begin
      sen = 1'b1; sdi = v[i];
      tick();
    end
    n_checks++;
    if ({out_valid, code_out, err_short} !== {1'b1, 8'h81, 1'b1}) begin
      n_fail++; $display("FAIL short_next got=%b/%h/%b exp=1/81/1", out_valid, code_out, err_short);
    end
    sen = 1'b0;
    tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    n_checks++;
    if (err_short !== 1'b0) begin n_fail++; $display("FAIL short_clr got=%b exp=0", err_short); end
  endtask

  task automatic test_async_reset();
    logic [7:0] v = 8'hC3;
    out_ready = 1'b1;
    for (int i = 7; i >= 5; i--) begin
      sen = 1'b1; sdi = v[i];
      tick();
    end
    sdi = v[4];
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if ({code_out, out_valid, busy, err_short, err_overrun} !== 12'h000) begin
      n_fail++;
      $display("FAIL async_rst got=%h/%b%b%b%b exp=00/0000", code_out, out_valid, busy,
               err_short, err_overrun);
    end
    // sen already high at release: first edge after release starts a frame.
    sen = 1'b1; sdi = 1'b1;
    #2 reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
    end
    n_checks++;
    if ({out_valid, code_out} !== {1'b1, 8'hFF}) begin
      n_fail++; $display("FAIL async_next got=%b/%h exp=1/ff", out_valid, code_out);
    end
    sen = 1'b0; sdi = 1'b0;
    tick();
  endtask

  task automatic test_long();
    logic [9:0] p = {8'h5A, 2'b11};
    out_ready = 1'b1;
    for (int i = 9; i >= 0; i--) begin
      sen = 1'b1; sdi = p[i];
      tick();
      if (i == 2) begin
        n_checks++;
        if ({out_valid, code_out} !== {1'b1, 8'h5A}) begin
          n_fail++; $display("FAIL long_code got=%b/%h exp=1/5a", out_valid, code_out);
        end
      end
      if (i == 1) begin
        n_checks++;
        if ({out_valid, busy, err_overrun} !== 3'b001) begin
          n_fail++;
          $display("FAIL long_overrun got=%b%b%b exp=001", out_valid, busy, err_overrun);
        end
      end
    end
    sen = 1'b0; sdi = 1'b0;
    tick();
    n_checks++;
    if ({out_valid, busy, code_out} !== {2'b00, 8'h5A}) begin
      n_fail++; $display("FAIL long_nofrm got=%b%b/%h exp=00/5a", out_valid, busy, code_out);
    end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
  endtask

  task automatic test_clr_same();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sen = 1'b1; sdi = 1'b1;
      tick();
    end
    sen = 1'b0; err_clr = 1'b1;
    tick();
    n_checks++;
    if (err_short !== 1'b1) begin n_fail++; $display("FAIL clr_same got=%b exp=1", err_short); end
    tick();
    err_clr = 1'b0;
    n_checks++;
    if (err_short !== 1'b0) begin n_fail++; $display("FAIL clr_next got=%b exp=0", err_short); end
    n_checks++;
    if ({out_valid, code_out} !== {1'b0, 8'h5A}) begin
      n_fail++; $display("FAIL clr_code got=%b/%h exp=0/5a", out_valid, code_out);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hold();
    test_short();
    test_async_reset();
    test_long();
    test_clr_same();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
